// File: rtl/mips_pkg.sv
// ============================================================================
//  Module  : mips_pkg
//  Brief   : Shared extender mode encodings, default widths and occupancy states.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    localparam logic [1:0] EXT_SIGN   = 2'b00;
    localparam logic [1:0] EXT_ZERO   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

endpackage

`default_nettype wire

// File: rtl/imm_ext_core.sv
// ============================================================================
//  Module  : imm_ext_core
//  Brief   : Combinational immediate extender (sign / zero / upper / branch).
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module imm_ext_core
    import mips_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_zero;

    assign w_sign = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign w_zero = {{(OUT_W-IN_W){1'b0}}, imm};

    // Shifting the zero-extended value by OUT_W-IN_W lands imm in the top bits,
    // and truncates naturally when OUT_W < 2*IN_W.
    always_comb begin
        ext = w_sign;
        case (mode)
            EXT_SIGN:   ext = w_sign;
            EXT_ZERO:   ext = w_zero;
            EXT_UPPER:  ext = w_zero << (OUT_W - IN_W);
            EXT_BRANCH: ext = w_sign << 2;
            default:    ext = w_sign;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_extend_pipe.sv
// ============================================================================
//  Module  : imm_extend_pipe
//  Brief   : Immediate extender behind a valid/ready stage with a one-entry skid.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module imm_extend_pipe
    import mips_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_extend_pipe: OUT_W must be >= IN_W+2");
    end

    occ_state_t       r_state;
    occ_state_t       w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_oreg_data;
    logic [TAG_W-1:0] r_oreg_tag;
    logic [OUT_W-1:0] r_skid_data;
    logic [TAG_W-1:0] r_skid_tag;
    logic [OUT_W-1:0] w_ext;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_load_oreg_ext;
    logic             w_load_oreg_skid;
    logic             w_load_skid;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .ext  (w_ext)
    );

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_oreg_ext  = 1'b0;
        w_load_oreg_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt     = ST_ONE;
                    w_load_oreg_ext = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_oreg_ext = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_xfer) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_out_xfer) begin
                    w_state_nxt      = ST_ONE;
                    w_load_oreg_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so neither side sees
    // a combinational path from the other.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_oreg_data <= '0;
            r_oreg_tag  <= '0;
            r_skid_data <= '0;
            r_skid_tag  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            if (w_load_oreg_ext) begin
                r_oreg_data <= w_ext;
                r_oreg_tag  <= in_tag;
            end else if (w_load_oreg_skid) begin
                r_oreg_data <= r_skid_data;
                r_oreg_tag  <= r_skid_tag;
            end
            if (w_load_skid) begin
                r_skid_data <= w_ext;
                r_skid_tag  <= in_tag;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_oreg_data;
    assign out_tag   = r_oreg_tag;

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
// ============================================================================
//  Module  : tb_imm_extend_pipe
//  Brief   : Directed and randomized self-checking bench for imm_extend_pipe.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int checks;
    int failures;

    imm_extend_pipe #(
        .IN_W  (16),
        .OUT_W (32),
        .TAG_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference extension for 16 -> 32 bits.
    function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] s;
        s = {{16{imm[15]}}, imm};
        case (mode)
            2'b00:   return s;
            2'b01:   return {16'h0000, imm};
            2'b10:   return {imm, 16'h0000};
            default: return {s[29:0], 2'b00};
        endcase
    endfunction

    task automatic apply_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = '0; in_mode = '0; in_tag = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: valid=%b data=%h tag=%h in_ready=%b, want 0/00000000/00/1",
                     out_valid, out_data, out_tag, in_ready);
        end
    endtask

    task automatic test_modes;
        logic [31:0] exp_data [4];
        exp_data[0] = 32'hFFFF8001;
        exp_data[1] = 32'h00008001;
        exp_data[2] = 32'h80010000;
        exp_data[3] = 32'hFFFE0004;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'(i); in_tag = 5'(i + 3);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data[i] || out_tag !== 5'(i + 3)) begin
                failures++;
                $display("FAIL mode%0d: valid=%b data=%h tag=%h, want 1/%h/%h",
                         i, out_valid, out_data, out_tag, exp_data[i], 5'(i + 3));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mode_drain: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_imm = 16'h0100 + 16'(i); in_mode = 2'b01; in_tag = 5'(i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h0100 + 32'(i) || out_tag !== 5'(i) || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b%0d: valid=%b data=%h tag=%h rdy=%b, want 1/%h/%h/1",
                         i, out_valid, out_data, out_tag, in_ready, 32'h0100 + 32'(i), 5'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h0010; in_mode = 2'b00; in_tag = 5'd1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000010 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_a: valid=%b data=%h rdy=%b, want 1/00000010/1", out_valid, out_data, in_ready);
        end
        in_imm = 16'h7FFF; in_mode = 2'b01; in_tag = 5'd2;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'h00000010 || out_tag !== 5'd1) begin
            failures++;
            $display("FAIL stall_full: rdy=%b data=%h tag=%h, want 0/00000010/01", in_ready, out_data, out_tag);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h00000010) begin
            failures++;
            $display("FAIL stall_hold: rdy=%b valid=%b data=%h, want 0/1/00000010", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00007FFF || out_tag !== 5'd2 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_b: valid=%b data=%h tag=%h rdy=%b, want 1/00007fff/02/1",
                     out_valid, out_data, out_tag, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_hold_full;
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b01; in_tag = 5'd10;
        tick();
        in_imm = 16'h0FFF; in_mode = 2'b10; in_tag = 5'd11;
        tick();
        in_imm = 16'hFFFF; in_mode = 2'b11; in_tag = 5'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_data !== 32'h00001234 || out_tag !== 5'd10) begin
                failures++;
                $display("FAIL full_hold%0d: rdy=%b data=%h tag=%h, want 0/00001234/0a",
                         i, in_ready, out_data, out_tag);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0FFF0000 || out_tag !== 5'd11 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_d: valid=%b data=%h tag=%h rdy=%b, want 1/0fff0000/0b/1",
                     out_valid, out_data, out_tag, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFC || out_tag !== 5'd12) begin
            failures++;
            $display("FAIL full_e: valid=%b data=%h tag=%h, want 1/fffffffc/0c", out_valid, out_data, out_tag);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_once: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_full;
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'hAAAA; in_mode = 2'b00; in_tag = 5'd20;
        tick();
        in_imm = 16'h5555; in_tag = 5'd21;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_full: valid=%b data=%h rdy=%b, want 0/00000000/1", out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_replay%0d: out_valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random;
        logic [36:0] q[$];
        logic        stalled;
        logic [31:0] held_data;
        logic [4:0]  held_tag;
        apply_reset();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            in_tag    = 5'($urandom_range(0, 31));
            checks++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0)) begin
                failures++;
                $display("FAIL rnd_flags c%0d: rdy=%b valid=%b occ=%0d", c, in_ready, out_valid, q.size());
            end
            if (out_valid === 1'b1 && out_ready === 1'b1 && q.size() != 0) begin
                checks++;
                if ({out_tag, out_data} !== q[0]) begin
                    failures++;
                    $display("FAIL rnd_data c%0d: got %h/%h want %h/%h", c, out_tag, out_data, q[0][36:32], q[0][31:0]);
                end
                void'(q.pop_front());
            end
            if (in_valid === 1'b1 && in_ready === 1'b1)
                q.push_back({in_tag, ext_model(in_imm, in_mode)});
            stalled   = (out_valid === 1'b1) && (out_ready === 1'b0);
            held_data = out_data;
            held_tag  = out_tag;
            tick();
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_tag !== held_tag) begin
                    failures++;
                    $display("FAIL rnd_stable c%0d: valid=%b data=%h tag=%h want 1/%h/%h",
                             c, out_valid, out_data, out_tag, held_data, held_tag);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_modes();
        test_back_to_back();
        test_stall();
        test_hold_full();
        test_reset_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
